stream_mux_n: RTL and testbench
===============================

// Module: stream_mux_n
// PURPOSE
//  - N-channel, WIDTH-bit registered selector with valid/ready handshakes; next generation of the 2:1 datapath mux.
//  - Channel choice is either an external select (MODE_SEL) or round-robin arbitration (MODE_RR).
//  - One output register stage, so a datapath join can be pipelined without losing throughput.
//  - Sits between producer units (ALU, load unit, CSR read) and a shared writeback/result bus.
// PARAMETERS
//  WIDTH  32             data width per channel
//  N      4              number of input channels, N >= 2
//  MODE   0              0 = MODE_SEL (sel port chooses), 1 = MODE_RR (round-robin)
//  SELW   $clog2(N)      select/source index width (derived, do not override)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous reset, active low
//  in_data    in   N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N        channel i presents data
//  in_ready   out  N        channel i accepted this cycle when in_valid[i] & in_ready[i]
//  sel        in   SELW     channel index, used only in MODE_SEL
//  out_data   out  WIDTH    registered selected data
//  out_valid  out  1        out_data holds an untaken word
//  out_ready  in   1        consumer takes the word when out_valid & out_ready
//  out_src    out  SELW     index of the channel that produced out_data
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_src=0, rr_ptr=N-1. Any held word is dropped.
//  - load_en = ~out_valid | out_ready (register empty, or draining this cycle).
//  - Grant (combinational, at most one channel):
//    - MODE_SEL: grant = sel if in_valid[sel] and sel < N; otherwise no grant.
//    - MODE_RR: first i with in_valid[i], scanning rr_ptr+1, rr_ptr+2, ... and wrapping modulo N.
//  - in_ready[i] = load_en & (grant == i) & grant_valid. All other in_ready bits are 0. in_ready never depends on in_valid of another channel in MODE_SEL.
//  - Transfer in: at posedge with grant_valid & load_en, out_data <= chosen data, out_src <= grant, out_valid <= 1.
//    - In MODE_RR, rr_ptr <= grant at the same edge.
//  - Drain: at posedge with out_valid & out_ready and no transfer in, out_valid <= 0. out_data and out_src hold their value.
//  - Simultaneous drain and load: the new word replaces the old in the same cycle, for 1 word/cycle throughput.
//  - Stall: while out_valid & ~out_ready, out_data, out_src and rr_ptr are frozen and all in_ready = 0.
//  - Latency is 1 cycle from input handshake to out_valid.
//  - No combinational path from in_data to out_data.
//  - There is a combinational path out_ready -> in_ready. This is intentional; there is no skid buffer.
//  - sel is sampled only on a load edge. Changing sel during a stall has no effect on the held word.
//  - rr_ptr changes only on a successful load. Idle cycles do not rotate priority.
//  - Out-of-range sel (N not a power of 2): no grant, no load, out_valid drains normally.
// STRUCTURE
//  - Package stream_mux_pkg holds: localparams MODE_SEL=0 and MODE_RR=1, and function clog2_min1 (SELW >= 1).
//  - Sub-module rr_arbiter_n #(N): inputs req[N] and ptr[SELW]; outputs gnt_idx[SELW] and gnt_valid.
//    - Used only when MODE==MODE_RR, via a generate block.
//  - Top level contains: grant mux, load_en logic, output register, and rr_ptr register.
// TESTING
//  1. Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 during reset.
//     Then rst_n=1 in MODE_RR -> first grant goes to ch0.
//  2. MODE_SEL, sel=2, in_data[2]=32'hDEADBEEF, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100.
//     Next cycle: out_valid=1, out_data=32'hDEADBEEF, out_src=2.
//  3. MODE_SEL stall: out_valid=1, out_ready=0 for 3 cycles while sel changes 2->1 -> in_ready=0 and out_data unchanged.
//     Then out_ready=1 -> ch1 is loaded on that edge.
//  4. MODE_RR, all 4 channels valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1, with no bubble cycles.
//  5. MODE_RR fairness: only ch3 and ch1 valid, rr_ptr=1 -> ch3 granted, then ch1.
//     Idle cycles inserted between grants leave the order unchanged.
//  6. Reset mid-operation: out_valid=1 with word pending, rst_n=0 for 1 cycle -> out_valid=0 and rr_ptr=N-1.
//     The pending word is never seen on the output.

Source files
------------

// File: rtl/stream_mux_n_pkg.sv
// Shared constants and helpers for the N-channel stream selector.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width for n items, never below one bit so that N == 1
  // style corner cases still produce legal vector declarations.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Bus bundle for stream_mux_n: N producer channels in, one registered
// result stream out.
//
// Handshake: a word moves across any valid/ready pair on a rising clk edge
// where both valid and ready are high. A producer holding valid keeps its
// data stable until it sees ready. ready may depend combinationally on the
// far side's ready (out_ready -> in_ready) but never on in_data.
interface stream_mux_n_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  import stream_mux_pkg::*;

  localparam int SELW = clog2_min1(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SELW-1:0]    out_src;

  // Producers plus consumer side (drives requests, takes results).
  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  // The selector itself.
  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: the channel just after ptr has highest priority,
// ptr itself lowest, wrapping modulo N.
module rr_arbiter_n
  import stream_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  // Scan from lowest priority to highest so the last hit wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_idx   = SELW'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered stream selector. Picks one channel per load (by
// external select or round-robin) into a single output register; the
// register reloads in the same cycle it drains for full throughput.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int SELW  = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_mux_n_if.slave   bus,
  output logic [SELW-1:0] rr_ptr
);

  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             load_en;
  logic             load;
  logic [WIDTH-1:0] chosen;

  // Register can accept when empty or when its word leaves this cycle.
  assign load_en = ~bus.out_valid | bus.out_ready;
  assign load    = load_en & grant_valid;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter_n #(.N(N)) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr),
        .gnt_idx   (grant),
        .gnt_valid (grant_valid)
      );
    end else begin : g_sel
      // Out-of-range select values match no channel, so they never grant.
      always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
            grant       = SELW'(i);
            grant_valid = 1'b1;
          end
        end
      end
    end
  endgenerate

  // One-hot ready to the granted channel; held low throughout reset.
  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (rst_n && load && grant == SELW'(i)) bus.in_ready[i] = 1'b1;
    end
  end

  // Data mux in front of the output register (no path to out_data).
  always_comb begin
    chosen = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) chosen = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer; pointer moves only on loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      rr_ptr        <= SELW'(N - 1);
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= chosen;
      bus.out_src   <= grant;
      if (MODE == MODE_RR) rr_ptr <= grant;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: one instance per mode, directed steps followed
// by a random phase, with a reference model feeding an expected queue.
module tb_stream_mux_n;
  import stream_mux_pkg::*;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SELW  = clog2_min1(N);
  localparam int W     = SELW + WIDTH;

  logic clk;
  logic rst_n;
  logic [SELW-1:0] ptr_sel;
  logic [SELW-1:0] ptr_rr;

  stream_mux_n_if #(.WIDTH(WIDTH), .N(N)) bus_sel ();
  stream_mux_n_if #(.WIDTH(WIDTH), .N(N)) bus_rr ();

  stream_mux_n #(.WIDTH(WIDTH), .N(N), .MODE(MODE_SEL)) u_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_sel),
    .rr_ptr (ptr_sel)
  );

  stream_mux_n #(.WIDTH(WIDTH), .N(N), .MODE(MODE_RR)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_rr),
    .rr_ptr (ptr_rr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: {src, data} per expected output word
  logic [W-1:0] exp_q_sel[$];
  logic [W-1:0] exp_q_rr[$];
  int           rr_log[$];
  logic         mv[2];
  int           mptr[2];
  logic         mrst[2];
  int           tests = 0;
  int           fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input int m, input logic [N-1:0] v,
                                     input logic [SELW-1:0] s, input int ptr);
    if (m == MODE_SEL) begin
      if (int'(s) < N && v[s]) return int'(s);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Check one DUT against the model, then advance the model over the coming edge.
  task automatic model_step(input int m);
    logic [N-1:0]       v, ir, exp_ir;
    logic [SELW-1:0]    s, os, rp;
    logic [N*WIDTH-1:0] d;
    logic               orr, ov, load, drain;
    logic [WIDTH-1:0]   od;
    logic [W-1:0]       head, nw;
    int                 g;
    string              p;
    if (m == MODE_SEL) begin
      v = bus_sel.in_valid; s = bus_sel.sel; d = bus_sel.in_data; orr = bus_sel.out_ready;
      ir = bus_sel.in_ready; ov = bus_sel.out_valid; od = bus_sel.out_data;
      os = bus_sel.out_src; rp = ptr_sel; p = "sel";
    end else begin
      v = bus_rr.in_valid; s = bus_rr.sel; d = bus_rr.in_data; orr = bus_rr.out_ready;
      ir = bus_rr.in_ready; ov = bus_rr.out_valid; od = bus_rr.out_data;
      os = bus_rr.out_src; rp = ptr_rr; p = "rr";
    end
    chk({p, "_out_valid"}, 64'(ov), 64'(mv[m]));
    chk({p, "_rr_ptr"}, 64'(rp), 64'(mptr[m]));
    if (mv[m]) begin
      if (m == MODE_SEL) head = (exp_q_sel.size() > 0) ? exp_q_sel[0] : 'x;
      else               head = (exp_q_rr.size() > 0) ? exp_q_rr[0] : 'x;
      chk({p, "_out_data"}, 64'(od), 64'(head[WIDTH-1:0]));
      chk({p, "_out_src"}, 64'(os), 64'(head[W-1:WIDTH]));
    end else if (mrst[m]) begin
      chk({p, "_out_data_rst"}, 64'(od), 64'd0);
      chk({p, "_out_src_rst"}, 64'(os), 64'd0);
    end
    g = model_grant(m, v, s, mptr[m]);
    load = rst_n && (!mv[m] || orr) && (g >= 0);
    exp_ir = '0;
    if (load) exp_ir[g] = 1'b1;
    chk({p, "_in_ready"}, 64'(ir), 64'(exp_ir));
    drain = mv[m] && orr;
    if (!rst_n) begin
      mv[m] = 1'b0; mptr[m] = N - 1; mrst[m] = 1'b1;
      if (m == MODE_SEL) exp_q_sel.delete(); else exp_q_rr.delete();
    end else begin
      if (drain) begin
        if (m == MODE_SEL) void'(exp_q_sel.pop_front());
        else begin
          void'(exp_q_rr.pop_front());
          rr_log.push_back(int'(os));
        end
      end
      if (load) begin
        nw = {SELW'(g), d[g*WIDTH +: WIDTH]};
        if (m == MODE_SEL) exp_q_sel.push_back(nw); else exp_q_rr.push_back(nw);
        mv[m] = 1'b1; mrst[m] = 1'b0;
        if (m == MODE_RR) mptr[m] = g;
      end else if (drain) begin
        mv[m] = 1'b0;
      end
    end
  endtask

  // One clock: check both DUTs mid-cycle, then step to just after the edge.
  task automatic cyc();
    @(negedge clk);
    model_step(MODE_SEL);
    model_step(MODE_RR);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data();
    for (int i = 0; i < N; i++) begin
      bus_sel.in_data[i*WIDTH +: WIDTH] = 32'h5E10_0000 | i;
      bus_rr.in_data[i*WIDTH +: WIDTH]  = 32'hA0A0_0000 | i;
    end
  endtask

  initial begin
    int exp_seq[6];
    int exp_fair[2];
    exp_seq  = '{0, 1, 2, 3, 0, 1};
    exp_fair = '{3, 1};
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; mptr[m] = N - 1; mrst[m] = 1'b1;
    end

    // Reset for two cycles with every channel requesting.
    rst_n = 1'b0;
    fill_data();
    bus_sel.in_valid = '1; bus_sel.sel = '0; bus_sel.out_ready = 1'b1;
    bus_rr.in_valid  = '1; bus_rr.sel  = '0; bus_rr.out_ready  = 1'b1;
    cyc();
    cyc();

    // Round-robin with all channels valid: ch0 first, then no bubbles.
    rst_n = 1'b1;
    bus_sel.in_valid = '0;
    rr_log.delete();
    cyc();
    chk("rr_first_grant", 64'(bus_rr.out_src), 64'd0);
    for (int i = 0; i < 6; i++) cyc();
    chk("rr_seq_len", 64'(rr_log.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < rr_log.size()) chk($sformatf("rr_seq_%0d", i), 64'(rr_log[i]), 64'(exp_seq[i]));
    bus_rr.in_valid = '0;
    cyc();

    // Select mode single transfer from ch2.
    bus_sel.sel = 2'd2;
    bus_sel.in_data[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    bus_sel.in_valid = 4'b0100;
    cyc();
    chk("sel_load_valid", 64'(bus_sel.out_valid), 64'd1);
    chk("sel_load_data", 64'(bus_sel.out_data), 64'hDEADBEEF);
    chk("sel_load_src", 64'(bus_sel.out_src), 64'd2);

    // Stall three cycles while sel moves to ch1; held word must not change.
    bus_sel.out_ready = 1'b0;
    bus_sel.in_valid = 4'b0110;
    bus_sel.in_data[1*WIDTH +: WIDTH] = 32'h1111_0001;
    bus_sel.sel = 2'd1;
    for (int i = 0; i < 3; i++) cyc();
    chk("sel_stall_data", 64'(bus_sel.out_data), 64'hDEADBEEF);
    bus_sel.out_ready = 1'b1;
    cyc();
    chk("sel_after_stall_src", 64'(bus_sel.out_src), 64'd1);
    chk("sel_after_stall_data", 64'(bus_sel.out_data), 64'h1111_0001);
    bus_sel.in_valid = '0;
    cyc();

    // Fairness: park pointer on ch1, then ch3 and ch1 compete.
    bus_rr.in_valid = 4'b0010;
    cyc();
    bus_rr.in_valid = '0;
    cyc();
    chk("rr_ptr_setup", 64'(ptr_rr), 64'd1);
    rr_log.delete();
    bus_rr.in_valid = 4'b1010;
    cyc();
    bus_rr.in_valid = '0;
    cyc();
    cyc();
    chk("rr_ptr_idle_hold", 64'(ptr_rr), 64'd3);
    bus_rr.in_valid = 4'b1010;
    cyc();
    bus_rr.in_valid = '0;
    cyc();
    cyc();
    chk("rr_fair_len", 64'(rr_log.size()), 64'd2);
    for (int i = 0; i < 2; i++)
      if (i < rr_log.size()) chk($sformatf("rr_fair_%0d", i), 64'(rr_log[i]), 64'(exp_fair[i]));

    // Reset while a word is held: it must never reach the consumer.
    bus_rr.in_valid = 4'b0100;
    bus_rr.out_ready = 1'b0;
    cyc();
    rr_log.delete();
    bus_rr.in_valid = '0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus_rr.out_ready = 1'b1;
    cyc();
    chk("rst_mid_valid", 64'(bus_rr.out_valid), 64'd0);
    chk("rst_mid_ptr", 64'(ptr_rr), 64'(N - 1));
    cyc();
    chk("rst_mid_no_word", 64'(rr_log.size()), 64'd0);

    // Random traffic on both instances.
    for (int c = 0; c < 80; c++) begin
      bus_sel.in_valid  = N'($urandom_range(0, (1 << N) - 1));
      bus_sel.sel       = SELW'($urandom_range(0, N - 1));
      bus_sel.out_ready = ($urandom_range(0, 3) != 0);
      bus_rr.in_valid   = N'($urandom_range(0, (1 << N) - 1));
      bus_rr.out_ready  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        bus_sel.in_data[i*WIDTH +: WIDTH] = $urandom;
        bus_rr.in_data[i*WIDTH +: WIDTH]  = $urandom;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
